// File: rtl/lsu_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
`timescale 1ns/1ps
interface lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding access, byte/half/word lanes, misalignment
// detection and a per-phase bus timeout.
`timescale 1ns/1ps
module lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        stall,
    lsu_if.master       bus,
    output logic        resp_valid,
    output logic [31:0] resp_mdata,
    output logic        misaligned,
    output logic        bus_err
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    size_t         size_q;
    logic [1:0]    off_q;
    logic [31:2]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mdata_q;
    logic          mis_q, err_q;

    logic          accept, acc_store, acc_mis, timeout_hit, cap_rdata, set_err;
    size_t         acc_size;
    logic [3:0]    acc_be;
    logic [31:0]   acc_wdata, load_lane;

    assign req_ready   = (state_q == S_IDLE) || (state_q == S_RESP);
    assign accept      = req_ready && req_valid && (load || store) && !rst;
    assign acc_store   = store && !load;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LIMIT);

    // Loads use the full funct3 (unsigned variants share lanes); stores effectively use funct3[1:0].
    always_comb begin
        case (funct3)
            3'd0, 3'd4: acc_size = SZ_B;
            3'd1, 3'd5: acc_size = SZ_H;
            default:    acc_size = SZ_W;
        endcase
    end

    always_comb begin
        acc_mis   = 1'b0;
        acc_be    = 4'hf;
        acc_wdata = wdata;
        case (acc_size)
            SZ_B: begin
                acc_be    = 4'b0001 << addr[1:0];
                acc_wdata = {4{wdata[7:0]}};
            end
            SZ_H: begin
                acc_mis   = addr[0];
                acc_be    = 4'b0011 << {addr[1], 1'b0};
                acc_wdata = {2{wdata[15:0]}};
            end
            default: acc_mis = (addr[1:0] != 2'b00);
        endcase
        if (!acc_store) acc_wdata = '0;
    end

    always_comb begin
        case (size_q)
            SZ_B:    load_lane = (bus.mem_rdata >> {off_q, 3'b000}) & 32'h0000_00ff;
            SZ_H:    load_lane = (bus.mem_rdata >> {off_q[1], 4'b0000}) & 32'h0000_ffff;
            default: load_lane = bus.mem_rdata;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        cap_rdata = 1'b0;
        set_err   = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) state_d = acc_mis ? S_RESP : S_REQ;
                else        state_d = S_IDLE;
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d   = S_RESP;
                    cap_rdata = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                    set_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_B;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            mdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= acc_store;
                size_q  <= acc_size;
                off_q   <= addr[1:0];
                addr_q  <= addr[31:2];
                be_q    <= acc_be;
                wdata_q <= acc_wdata;
                mdata_q <= '0;
                mis_q   <= acc_mis;
                err_q   <= 1'b0;
            end
            if (cap_rdata) mdata_q <= load_lane;
            if (set_err) begin
                err_q   <= 1'b1;
                mdata_q <= '0;
            end
        end
    end

    // Bus fields only change on accept, which cannot happen while mem_req is high.
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = {addr_q, 2'b00};
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

    assign stall      = (state_q == S_REQ) || (state_q == S_WAIT) || ((state_q == S_IDLE) && accept);
    assign resp_valid = (state_q == S_RESP);
    assign resp_mdata = mdata_q;
    assign misaligned = resp_valid && mis_q;
    assign bus_err    = resp_valid && err_q;
endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a timeline/lane reference model.
`timescale 1ns/1ps
module tb_lsu;
    localparam int TO = 4;

    typedef struct {
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rdata;
        int          gd, rd;
    } txn_t;

    typedef struct {
        logic        mis, we, err;
        logic [3:0]  be;
        logic [31:0] wd, md;
        int          req_n, wait_n, resp_at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, req_valid, load, store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        req_ready, stall, resp_valid, misaligned, bus_err;
    logic [31:0] resp_mdata;

    int tests  = 0;
    int failed = 0;

    lsu_if bus();

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .load(load), .store(store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .req_ready(req_ready), .stall(stall),
        .bus(bus), .resp_valid(resp_valid), .resp_mdata(resp_mdata),
        .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Reference: sizes, lanes and cycle counts straight from the access rules.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int sz, lane, f;
        f = int'(t.f3);
        if (t.ld) sz = (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : 4;
        else      sz = (f % 4 == 0) ? 1 : (f % 4 == 1) ? 2 : 4;
        lane  = int'(t.addr % 4);
        e.we  = !t.ld;
        e.mis = (sz == 2 && t.addr % 2 != 0) || (sz == 4 && lane != 0);
        e.be  = (sz == 1) ? 4'(1 << lane) : (sz == 2) ? ((lane >= 2) ? 4'b1100 : 4'b0011) : 4'b1111;
        if (!e.we)        e.wd = 0;
        else if (sz == 1) e.wd = (t.wdata & 32'hff) * 32'h0101_0101;
        else if (sz == 2) e.wd = (t.wdata & 32'hffff) * 32'h0001_0001;
        else              e.wd = t.wdata;
        e.err = 0; e.md = 0; e.req_n = 0; e.wait_n = 0;
        if (e.mis) begin
            e.resp_at = 1;
        end else if (t.gd >= TO) begin
            e.req_n = TO; e.err = 1; e.resp_at = TO + 1;
        end else begin
            e.req_n = t.gd + 1;
            if (e.we) begin
                e.resp_at = e.req_n + 1;
            end else begin
                if (t.rd >= TO) begin
                    e.wait_n = TO; e.err = 1;
                end else begin
                    e.wait_n = t.rd + 1;
                    if (sz == 1)      e.md = (t.rdata >> (8 * lane)) & 32'hff;
                    else if (sz == 2) e.md = (t.rdata >> (16 * (lane / 2))) & 32'hffff;
                    else              e.md = t.rdata;
                end
                e.resp_at = e.req_n + e.wait_n + 1;
            end
        end
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.ld    = 1'($urandom % 2);
        t.st    = t.ld ? 1'($urandom % 2) : 1'b1;
        t.f3    = 3'($urandom % 8);
        t.addr  = $urandom;
        if ($urandom % 2 == 0) t.addr[1:0] = 2'b00;
        t.wdata = $urandom;
        t.rdata = $urandom;
        t.gd    = $urandom_range(0, 5);
        t.rd    = $urandom_range(0, 5);
        return t;
    endfunction

    function automatic txn_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdt, input int gd, input int rd);
        txn_t t;
        t.ld = ld; t.st = st; t.f3 = f3; t.addr = a; t.wdata = wd; t.rdata = rdt;
        t.gd = gd; t.rd = rd;
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        req_valid = 1'b1; load = t.ld; store = t.st; funct3 = t.f3; addr = t.addr; wdata = t.wdata;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0; load = 1'($urandom % 2); store = 1'($urandom % 2);
        funct3 = 3'($urandom % 8); addr = $urandom; wdata = $urandom;
    endtask

    // Runs one access; the accept cycle is the previous RESP cycle when chained.
    task automatic run_txn(input txn_t t, input bit chained, input bit has_next, input txn_t n);
        exp_t e;
        bit   in_wait;
        e = model(t);
        if (!chained) begin
            @(posedge clk); #1;
            drive_req(t);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'($urandom % 2); bus.mem_rdata = $urandom;
            #1;
            tests++;
            if (req_ready !== 1'b1 || stall !== 1'b1) begin
                failed++;
                $display("FAIL accept_cycle: req_ready=%b stall=%b, want 1 1", req_ready, stall);
            end
        end
        for (int c = 1; c <= e.resp_at; c++) begin
            @(posedge clk); #1;
            if (c == e.resp_at && has_next) drive_req(n);
            else                            drive_idle();
            in_wait = !e.mis && !e.we && (c > e.req_n) && (c <= e.req_n + e.wait_n);
            bus.mem_gnt = (!e.mis && t.gd < TO && c == t.gd + 1);
            if (in_wait) begin
                bus.mem_rvalid = (c == e.req_n + 1 + t.rd);
                bus.mem_rdata  = bus.mem_rvalid ? t.rdata : $urandom;
            end else begin
                bus.mem_rvalid = 1'($urandom % 2);
                bus.mem_rdata  = $urandom;
            end
            #1;
            tests++;
            if (bus.mem_req !== (c <= e.req_n) || stall !== (c < e.resp_at)
                || resp_valid !== (c == e.resp_at)) begin
                failed++;
                $display("FAIL timeline c=%0d: mem_req=%b stall=%b resp_valid=%b, want %b %b %b",
                         c, bus.mem_req, stall, resp_valid, c <= e.req_n, c < e.resp_at, c == e.resp_at);
            end
            if (c <= e.req_n) begin
                tests++;
                if (bus.mem_addr !== (t.addr & ~32'h3) || bus.mem_be !== e.be
                    || bus.mem_we !== e.we || bus.mem_wdata !== e.wd) begin
                    failed++;
                    $display("FAIL bus_fields c=%0d: addr=%h be=%b we=%b wdata=%h, want %h %b %b %h",
                             c, bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata,
                             t.addr & ~32'h3, e.be, e.we, e.wd);
                end
            end
            if (c == e.resp_at) begin
                tests++;
                if (resp_mdata !== e.md || misaligned !== e.mis || bus_err !== e.err
                    || req_ready !== 1'b1) begin
                    failed++;
                    $display("FAIL response: mdata=%h mis=%b err=%b ready=%b, want %h %b %b 1",
                             resp_mdata, misaligned, bus_err, req_ready, e.md, e.mis, e.err);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #2;
        tests++;
        if (req_ready !== 1'b1 || stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0
            || bus.mem_addr !== 32'h0 || bus.mem_be !== 4'h0 || bus.mem_wdata !== 32'h0
            || resp_valid !== 1'b0 || resp_mdata !== 32'h0 || misaligned !== 1'b0 || bus_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_outputs: ready=%b stall=%b req=%b be=%b resp=%b mdata=%h",
                     req_ready, stall, bus.mem_req, bus.mem_be, resp_valid, resp_mdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        txn_t none;
        none = mk(0, 1, 0, 0, 0, 0, 0, 0);
        run_txn(mk(0, 1, 3'd0, 32'h103, 32'h0000_00a5, 32'h0, 0, 0), 0, 0, none);
        run_txn(mk(1, 0, 3'd5, 32'h202, 32'h0, 32'hbeef_1234, 0, 0), 0, 0, none);
        run_txn(mk(1, 0, 3'd2, 32'h301, 32'h0, 32'h0, 0, 0), 0, 0, none);
        run_txn(mk(1, 1, 3'd2, 32'h480, 32'h1234_5678, 32'hcafe_f00d, 1, 1), 0, 0, none);
    endtask

    task automatic test_wait_grant();
        txn_t none;
        none = mk(0, 1, 0, 0, 0, 0, 0, 0);
        run_txn(mk(0, 1, 3'd2, 32'h40, 32'hdead_beef, 32'h0, 3, 0), 0, 0, none);
        run_txn(mk(0, 1, 3'd1, 32'h46, 32'h0000_5a5a, 32'h0, 2, 0), 0, 0, none);
    endtask

    task automatic test_timeout();
        txn_t none;
        none = mk(0, 1, 0, 0, 0, 0, 0, 0);
        run_txn(mk(1, 0, 3'd2, 32'h500, 32'h0, 32'hffff_ffff, 0, 9), 0, 0, none);
        run_txn(mk(0, 1, 3'd2, 32'h504, 32'h1111_2222, 32'h0, 7, 0), 0, 0, none);
    endtask

    task automatic test_ignored();
        @(posedge clk); #1;
        req_valid = 1'b1; load = 1'b0; store = 1'b0; addr = 32'h600; funct3 = 3'd2;
        #1;
        tests++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            failed++;
            $display("FAIL ignored_accept: stall=%b ready=%b, want 0 1", stall, req_ready);
        end
        @(posedge clk); #1;
        drive_idle();
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL ignored_next: mem_req=%b resp_valid=%b stall=%b, want 0 0 0",
                     bus.mem_req, resp_valid, stall);
        end
    endtask

    task automatic test_back_to_back();
        txn_t a, b, c, none;
        none = mk(0, 1, 0, 0, 0, 0, 0, 0);
        a = mk(0, 1, 3'd0, 32'h701, 32'h0000_003c, 32'h0, 0, 0);
        b = mk(1, 0, 3'd0, 32'h713, 32'h0, 32'h89ab_cdef, 0, 0);
        c = mk(1, 0, 3'd1, 32'h721, 32'h0, 32'h0, 0, 0);
        run_txn(a, 0, 1, b);
        run_txn(b, 1, 1, c);
        run_txn(c, 1, 1, a);
        run_txn(a, 1, 0, none);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive_req(mk(1, 0, 3'd2, 32'h800, 32'h0, 32'h0, 0, 0));
        @(posedge clk); #1;
        drive_idle();
        bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b0;
        @(posedge clk); #1;
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        #1;
        tests++;
        if (bus.mem_req !== 1'b0 || resp_valid !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1
            || bus.mem_be !== 4'h0 || resp_mdata !== 32'h0) begin
            failed++;
            $display("FAIL reset_mid: mem_req=%b resp_valid=%b stall=%b ready=%b be=%b mdata=%h",
                     bus.mem_req, resp_valid, stall, req_ready, bus.mem_be, resp_mdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            bus.mem_rvalid = 1'($urandom % 2);
            #1;
            tests++;
            if (resp_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
                failed++;
                $display("FAIL reset_mid_after %0d: resp_valid=%b mem_req=%b, want 0 0",
                         i, resp_valid, bus.mem_req);
            end
        end
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        txn_t cur, nxt;
        bit   prev_chain, chain;
        prev_chain = 0;
        cur = rand_txn();
        for (int i = 0; i < 60; i++) begin
            nxt   = rand_txn();
            chain = (i != 59) && ($urandom % 2 == 1);
            run_txn(cur, prev_chain, chain, nxt);
            prev_chain = chain;
            cur = nxt;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wait_grant();
        test_timeout();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-wait cycle limit per phase; 0 disables the timeout.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  memory-stage instruction present.
REQ-005 load  in  1  instruction is a load.
REQ-006 store  in  1  instruction is a store.
REQ-007 funct3  in  3  access size/type (0 byte, 1 half, 2 word, 4 byte-unsigned, 5 half-unsigned).
REQ-008 addr  in  32  byte address from the ALU.
REQ-009 wdata  in  32  store data (rs2), lane 0 aligned.
REQ-010 req_ready  out  1  request can be accepted this cycle.
REQ-011 stall  out  1  pipeline hold.
REQ-012 mem_req, mem_we  out  1 each  bus request and write flag.
REQ-013 mem_addr  out  32  word address, with bits [1:0] = 0.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_wdata  out  32  lane-positioned write data.
REQ-016 mem_gnt, mem_rvalid  in  1 each  bus grant and read-data valid.
REQ-017 mem_rdata  in  32  read data.
REQ-018 resp_valid  out  1  one-cycle completion pulse.
REQ-019 resp_mdata  out  32  load data shifted to lane 0, zero-filled; writeback performs the extension.
REQ-020 misaligned, bus_err  out  1 each  status flags, valid only with resp_valid.

Function
REQ-021 The block SHALL implement four states: IDLE, REQ, WAIT and RESP.
REQ-022 req_ready SHALL be 1 in IDLE and in RESP, so back-to-back accepts are allowed.
REQ-023 Accept SHALL occur when req_ready, req_valid and (load or store) are all 1; the block SHALL register the access type, size, address and data.
REQ-024 load=store=1 SHALL be treated as a load; load=store=0 SHALL be ignored.
REQ-025 Load funct3 values 3, 6 and 7 SHALL be treated as word; store funct3[1:0]=3 SHALL be treated as word.
REQ-026 Misalignment rules: a halfword with addr[0]=1, or a word with addr[1:0]!=0, SHALL not issue a bus request; the block SHALL go to RESP with misaligned=1.
REQ-027 An aligned accept SHALL go to REQ; mem_req SHALL be high on the cycle after accept and held until the cycle mem_gnt=1.
REQ-028 Byte enables: byte = 0001<<addr[1:0]; half = 0011<<{addr[1],0}; word = 1111.
REQ-029 Write data: byte = wdata[7:0] replicated x4; half = wdata[15:0] replicated x2; word = wdata.
REQ-030 mem_wdata SHALL be 0 for loads, and mem_we SHALL equal the registered store flag.
REQ-031 On grant, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-032 In WAIT, mem_rvalid=1 SHALL capture resp_mdata and then go to RESP.
REQ-033 Load alignment: byte = rdata>>(8*addr[1:0]); half = rdata>>(16*addr[1]); word unshifted; the upper bits SHALL be zero.
REQ-034 mem_rvalid SHALL be ignored outside WAIT, including on the grant cycle.
REQ-035 In RESP, resp_valid SHALL be 1 for exactly one cycle; the block then goes to IDLE, or to REQ/RESP on a new accept.
REQ-036 Minimum latency: a store completes at T+2 and a load at T+3 (T = accept cycle), given same-cycle grant and next-cycle rvalid.
REQ-037 stall SHALL be 1 in REQ and WAIT, and in the accept cycle when the accepted access is not already completing; it SHALL be 0 in the resp_valid cycle.
REQ-038 Timeout: a counter SHALL clear on entry to REQ and WAIT and increment each cycle in them.
REQ-039 When the counter reaches TIMEOUT with no grant/rvalid, the block SHALL deassert mem_req, go to RESP with bus_err=1 and set resp_mdata=0.
REQ-040 mem_addr, mem_be, mem_we and mem_wdata SHALL stay stable while mem_req=1.

Reset
REQ-041 When rst=1 at a clock edge, the block SHALL enter IDLE from any state.
REQ-042 During that reset, all outputs except req_ready SHALL be 0, the counter SHALL be 0, and req_ready SHALL be 1 after reset.
REQ-043 Reset mid-transaction SHALL abort the transaction: mem_req drops at that edge, no resp_valid is produced, and any late rvalid is ignored.

Verification
REQ-044 Store, sb: wdata=0x000000A5, addr=0x103, gnt on the first request cycle -> mem_addr=0x100, mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, resp_valid at T+2.
REQ-045 Load, lhu: addr=0x202, rdata=0xBEEF1234 one cycle after gnt -> mem_be=1100, resp_mdata=0x0000BEEF, resp_valid at T+3.
REQ-046 Misaligned lw at addr=0x301 -> mem_req is never asserted, resp_valid at T+1 with misaligned=1.
REQ-047 Grant withheld for 3 cycles on a sw -> mem_req held 4 cycles with stable outputs, stall=1 throughout, resp_valid one cycle after gnt.
REQ-048 Timeout with TIMEOUT=4 and no rvalid on a load -> bus_err=1, resp_mdata=0, resp_valid 4 cycles after WAIT entry.
REQ-049 rst asserted in WAIT, then rvalid next cycle -> block is in IDLE, no resp_valid, mem_req=0.
